// File: rtl/dsp_cfg_pkg.sv
// Shared types and constants for the DSP slice configuration-chain loader.
// Stage indices name the output-manager bits of the default 4-flop chain.
package dsp_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_RESP
   } state_t;

   localparam int OM_CHAIN_LEN = 4;

   localparam int AUTORESET_PATDET0  = 0;
   localparam int AUTORESET_PATDET1  = 1;
   localparam int AUTORESET_PRIORITY = 2;
   localparam int IS_RSTP_INVERTED   = 3;

endpackage

// File: rtl/dsp_config_loader_cfg_shift_reg.sv
// Transmit/capture shift registers for the configuration chain: rotates the command
// word out MSB-first and collects configuration_output MSB-first.
module cfg_shift_reg
   import dsp_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = OM_CHAIN_LEN
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [CHAIN_LEN-1:0] load_data,
   input  logic                 tx_shift,
   input  logic                 rx_shift,
   input  logic                 rx_in,
   output logic                 tx_bit,
   output logic [CHAIN_LEN-1:0] tx_word,
   output logic [CHAIN_LEN-1:0] rx_next
);

   logic [CHAIN_LEN-1:0] tx_q;
   logic [CHAIN_LEN-1:0] rx_q;

   // Rotation rather than a plain shift: after each full pass the word is back in
   // place, so the verify pass can re-send it and compare against it directly.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_q <= '0;
      end else if (load) begin
         tx_q <= load_data;
      end else if (tx_shift) begin
         tx_q <= (tx_q << 1) | (tx_q >> (CHAIN_LEN - 1));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_q <= '0;
      end else if (rx_shift) begin
         rx_q <= rx_next;
      end
   end

   assign tx_bit  = tx_q[CHAIN_LEN-1];
   assign tx_word = tx_q;
   // Includes the bit arriving on this edge, so the final capture is usable immediately.
   assign rx_next = (rx_q << 1) | CHAIN_LEN'(rx_in);

endmodule

// File: rtl/dsp_config_loader.sv
// Sequencer for a DSP slice serial configuration chain: shifts a command word in,
// returns the previous chain word, optionally re-shifts to verify, holds the slice meanwhile.
module dsp_config_loader
   import dsp_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = OM_CHAIN_LEN
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [CHAIN_LEN-1:0] cmd_data,
   input  logic                 cmd_verify,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CHAIN_LEN-1:0] rsp_rdata,
   output logic                 rsp_error,
   output logic                 configuration_input,
   output logic                 configuration_enable,
   input  logic                 configuration_output,
   output logic                 dsp_hold,
   output logic                 cfg_loaded
);

   localparam int            CW   = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN);

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic                 verify_q;
   logic                 ready_n, valid_n, err_n, cin_n, cen_n, hold_n, loaded_n;
   logic [CHAIN_LEN-1:0] rdata_n;
   logic                 load, tx_shift, tx_bit;
   logic [CHAIN_LEN-1:0] tx_word, rx_next;

   cfg_shift_reg #(.CHAIN_LEN(CHAIN_LEN)) u_shift (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (cmd_data),
      .tx_shift  (tx_shift),
      .rx_shift  (configuration_enable),
      .rx_in     (configuration_output),
      .tx_bit    (tx_bit),
      .tx_word   (tx_word),
      .rx_next   (rx_next)
   );

   // cnt counts bits already driven onto configuration_input in the current pass.
   // NOTE: every signal written here gets a default first, so no path infers a latch.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      ready_n  = cmd_ready;
      valid_n  = rsp_valid;
      rdata_n  = rsp_rdata;
      err_n    = rsp_error;
      cin_n    = configuration_input;
      cen_n    = configuration_enable;
      hold_n   = dsp_hold;
      loaded_n = cfg_loaded;
      load     = 1'b0;
      tx_shift = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_n = ST_LOAD;
               cnt_n   = '0;
               ready_n = 1'b0;
               load    = 1'b1;
            end
         end
         ST_LOAD, ST_VERIFY: begin
            if (cnt != LAST) begin
               cen_n    = 1'b1;
               hold_n   = 1'b1;
               cin_n    = tx_bit;
               tx_shift = 1'b1;
               cnt_n    = cnt + 1'b1;
            end else if (state == ST_LOAD && verify_q) begin
               // Verify pass follows with no gap: the first bit goes out on this edge.
               state_n  = ST_VERIFY;
               rdata_n  = rx_next;
               cin_n    = tx_bit;
               tx_shift = 1'b1;
               cnt_n    = CW'(1);
            end else begin
               state_n = ST_RESP;
               cen_n   = 1'b0;
               hold_n  = 1'b0;
               cin_n   = 1'b0;
               valid_n = 1'b1;
               if (state == ST_LOAD) begin
                  rdata_n  = rx_next;
                  err_n    = 1'b0;
                  loaded_n = 1'b1;
               end else begin
                  err_n    = (rx_next != tx_word);
                  loaded_n = (rx_next == tx_word);
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_n = ST_IDLE;
               valid_n = 1'b0;
               ready_n = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
            valid_n = 1'b0;
            cen_n   = 1'b0;
            hold_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                <= ST_IDLE;
         cnt                  <= '0;
         verify_q             <= 1'b0;
         cmd_ready            <= 1'b1;
         rsp_valid            <= 1'b0;
         rsp_rdata            <= '0;
         rsp_error            <= 1'b0;
         configuration_input  <= 1'b0;
         configuration_enable <= 1'b0;
         dsp_hold             <= 1'b0;
         cfg_loaded           <= 1'b0;
      end else begin
         state                <= state_n;
         cnt                  <= cnt_n;
         if (load) verify_q   <= cmd_verify;
         cmd_ready            <= ready_n;
         rsp_valid            <= valid_n;
         rsp_rdata            <= rdata_n;
         rsp_error            <= err_n;
         configuration_input  <= cin_n;
         configuration_enable <= cen_n;
         dsp_hold             <= hold_n;
         cfg_loaded           <= loaded_n;
      end
   end

endmodule

// File: tb/tb_dsp_config_loader.sv
// Directed bench for dsp_config_loader with a behavioural 4-flop chain and a
// response scoreboard derived from that chain model.
module tb_dsp_config_loader;
   import dsp_cfg_pkg::*;

   localparam logic [3:0] STUCK_MASK = 4'b1011;

   typedef struct packed {
      logic [3:0] rdata;
      logic       error;
      logic       loaded;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_data;
   logic       cmd_verify;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_rdata;
   logic       rsp_error;
   logic       configuration_input;
   logic       configuration_enable;
   logic       configuration_output;
   logic       dsp_hold;
   logic       cfg_loaded;

   logic [3:0] chain;
   logic       stuck_en;
   exp_t       sb[$];
   int         total;
   int         bad;

   dsp_config_loader #(.CHAIN_LEN(4)) dut (
      .clk                  (clk),
      .reset                (reset),
      .cmd_valid            (cmd_valid),
      .cmd_ready            (cmd_ready),
      .cmd_data             (cmd_data),
      .cmd_verify           (cmd_verify),
      .rsp_valid            (rsp_valid),
      .rsp_ready            (rsp_ready),
      .rsp_rdata            (rsp_rdata),
      .rsp_error            (rsp_error),
      .configuration_input  (configuration_input),
      .configuration_enable (configuration_enable),
      .configuration_output (configuration_output),
      .dsp_hold             (dsp_hold),
      .cfg_loaded           (cfg_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Chain model: bit i is stage i; stage 3 drives configuration_output.
   always @(posedge clk) begin
      if (configuration_enable)
         chain <= stuck_en ? ({chain[2:0], configuration_input} & STUCK_MASK)
                           : {chain[2:0], configuration_input};
   end
   assign configuration_output = chain[3];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full pass of the chain model: returns what falls out and what is left behind.
   function automatic void model_pass(input logic [3:0] c_in, input logic [3:0] w,
                                      input logic stuck, output logic [3:0] cap,
                                      output logic [3:0] c_out);
      logic [3:0] c;
      c   = c_in;
      cap = '0;
      for (int i = 3; i >= 0; i--) begin
         cap = {cap[2:0], c[3]};
         c   = {c[2:0], w[i]};
         if (stuck) c[AUTORESET_PRIORITY] = 1'b0;
      end
      c_out = c;
   endfunction

   task automatic do_cmd(input logic [3:0] word, input logic verify, input int hold_cycles,
                         input logic busy_pulse);
      int         guard;
      int         passes;
      int         en_cnt;
      logic [3:0] stream;
      logic [3:0] cap1, cap2, c1, c2;
      exp_t       e;
      exp_t       got;

      cmd_data   = word;
      cmd_verify = verify;
      cmd_valid  = 1'b1;
      guard      = 0;
      while (!cmd_ready && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);

      model_pass(chain, word, stuck_en, cap1, c1);
      model_pass(c1, word, stuck_en, cap2, c2);
      e.rdata  = cap1;
      e.error  = verify && (cap2 != word);
      e.loaded = !(verify && (cap2 != word));
      sb.push_back(e);

      step();  // accept edge T
      cmd_valid  = 1'b0;
      cmd_data   = ~word;
      cmd_verify = ~verify;
      check("ready_low_after_accept", cmd_ready, 1'b0);
      check("enable_idle_at_T", configuration_enable, 1'b0);

      passes = verify ? 8 : 4;
      en_cnt = 0;
      stream = '0;
      for (int k = 1; k <= passes; k++) begin
         cmd_valid = busy_pulse && (k == 2);
         step();
         if (configuration_enable && dsp_hold) en_cnt++;
         if (k <= 4) stream = {stream[2:0], configuration_input};
         if (rsp_valid) check("rsp_valid_early", rsp_valid, 1'b0);
      end
      cmd_valid = 1'b0;
      step();  // T + passes + 1
      check("enable_cycles", en_cnt, passes);
      check("serial_stream", stream, word);
      check("enable_dropped", configuration_enable, 1'b0);
      check("hold_dropped", dsp_hold, 1'b0);
      check("rsp_valid_on_time", rsp_valid, 1'b1);

      if (rsp_valid && sb.size() > 0) begin
         got = sb.pop_front();
         check("rsp_rdata", rsp_rdata, got.rdata);
         check("rsp_error", rsp_error, got.error);
         check("cfg_loaded", cfg_loaded, got.loaded);
      end else begin
         check("scoreboard_pop", rsp_valid, 1'b1);
         got = e;
      end
      if (!stuck_en) check("chain_contents", chain, word);

      for (int h = 0; h < hold_cycles; h++) begin
         step();
         check("hold_rsp_valid", rsp_valid, 1'b1);
         check("hold_rsp_rdata", rsp_rdata, got.rdata);
         check("hold_rsp_error", rsp_error, got.error);
         check("hold_cmd_ready", cmd_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      step();  // response handshake edge
      rsp_ready = 1'b0;
      check("ready_after_handshake", cmd_ready, 1'b1);
      check("valid_after_handshake", rsp_valid, 1'b0);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      chain      = 4'b0000;
      stuck_en   = 1'b0;
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_data   = '0;
      cmd_verify = 1'b0;
      rsp_ready  = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();

      check("reset_cmd_ready", cmd_ready, 1'b1);
      check("reset_outputs", {rsp_valid, rsp_error, configuration_enable, configuration_input,
                              dsp_hold, cfg_loaded, rsp_rdata}, 32'd0);

      do_cmd(4'b1011, 1'b0, 0, 1'b0);
      do_cmd(4'b0110, 1'b1, 3, 1'b1);
      do_cmd(4'b1001, 1'b0, 0, 1'b0);

      stuck_en = 1'b1;
      do_cmd(4'b1111, 1'b1, 1, 1'b0);
      check("stuck_error_seen", rsp_error, 1'b1);
      stuck_en = 1'b0;
      do_cmd(4'b0101, 1'b1, 0, 1'b0);

      cmd_data   = 4'b1100;
      cmd_verify = 1'b0;
      cmd_valid  = 1'b1;
      check("pre_reset_ready", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
      step();
      step();
      check("midload_enable", configuration_enable, 1'b1);
      reset = 1'b1;
      #1;
      check("async_enable_drop", configuration_enable, 1'b0);
      check("async_hold_drop", dsp_hold, 1'b0);
      check("async_loaded_clear", cfg_loaded, 1'b0);
      step();
      reset = 1'b0;
      step();
      check("ready_after_reset", cmd_ready, 1'b1);
      check("enable_after_reset", configuration_enable, 1'b0);

      do_cmd(4'b0011, 1'b1, 2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
